// File: rtl/fir_stream_engine_if.sv
// Bus bundle for fir_stream_engine: AXI-Lite control, AXI-Stream in/out and
// the two single-port BRAM ports (coefficients and sample history).
interface fir_stream_engine_if #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
);
  logic                   awvalid, awready;
  logic [pADDR_WIDTH-1:0] awaddr;
  logic                   wvalid, wready;
  logic [pDATA_WIDTH-1:0] wdata;
  logic                   arvalid, arready;
  logic [pADDR_WIDTH-1:0] araddr;
  logic                   rvalid, rready;
  logic [pDATA_WIDTH-1:0] rdata;
  logic                   ss_tvalid, ss_tready, ss_tlast;
  logic [pDATA_WIDTH-1:0] ss_tdata;
  logic                   sm_tvalid, sm_tready, sm_tlast;
  logic [pDATA_WIDTH-1:0] sm_tdata;
  logic [3:0]             tap_WE, data_WE;
  logic                   tap_EN, data_EN;
  logic [pDATA_WIDTH-1:0] tap_Di, tap_Do, data_Di, data_Do;
  logic [pADDR_WIDTH-1:0] tap_A, data_A;

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
           ss_tvalid, ss_tdata, ss_tlast, sm_tready, tap_Do, data_Do,
    output awready, wready, arready, rvalid, rdata, ss_tready,
           sm_tvalid, sm_tdata, sm_tlast,
           tap_WE, tap_EN, tap_Di, tap_A, data_WE, data_EN, data_Di, data_A
  );

  modport master (
    output awvalid, awaddr, wvalid, wdata, arvalid, araddr, rready,
           ss_tvalid, ss_tdata, ss_tlast, sm_tready, tap_Do, data_Do,
    input  awready, wready, arready, rvalid, rdata, ss_tready,
           sm_tvalid, sm_tdata, sm_tlast,
           tap_WE, tap_EN, tap_Di, tap_A, data_WE, data_EN, data_Di, data_A
  );
endinterface

// File: rtl/fir_stream_engine.sv
// Streaming FIR engine: AXI-Lite control/coefficients, runtime tap count,
// circular sample history in an external BRAM, backpressured result stream.
module fir_stream_engine #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pTAP_MAX    = 11
) (
  input logic                axis_clk,
  input logic                axis_rst_n,
  fir_stream_engine_if.slave bus
);
  localparam int IW = pADDR_WIDTH - 2;
  localparam logic [IW-1:0] LAST_IDX = IW'(pTAP_MAX - 1);
  localparam logic [pADDR_WIDTH-1:0] A_CTRL  = pADDR_WIDTH'(32'h00);
  localparam logic [pADDR_WIDTH-1:0] A_LEN   = pADDR_WIDTH'(32'h10);
  localparam logic [pADDR_WIDTH-1:0] A_TAPS  = pADDR_WIDTH'(32'h14);
  localparam logic [pADDR_WIDTH-1:0] COEF_LO = pADDR_WIDTH'(32'h20);
  localparam logic [pADDR_WIDTH-1:0] COEF_HI = pADDR_WIDTH'(32 + 4 * pTAP_MAX);

  localparam logic [2:0] S_IDLE = 3'd0, S_CLEAR = 3'd1, S_WAIT = 3'd2,
                         S_MAC  = 3'd3, S_OUT   = 3'd4;
  localparam logic [2:0] X_IDLE = 3'd0, X_WR = 3'd1, X_RA = 3'd2,
                         X_RW   = 3'd3, X_RD = 3'd4;

  logic [2:0]             st_q, st_d, ax_q, ax_d;
  logic                   ap_start_q, ap_start_d, ap_done_q, ap_done_d;
  logic                   ap_idle_q, ap_idle_d, err_q, err_d;
  logic                   last_rd_q, last_rd_d, mac_v_q, mac_v_d;
  logic [pDATA_WIDTH-1:0] len_q, len_d, taps_q, taps_d, acc_q, acc_d;
  logic [pDATA_WIDTH-1:0] nout_q, nout_d, rdata_q, rdata_d, prod;
  logic [IW-1:0]          wptr_q, wptr_d, k_q, k_d, hidx_q, hidx_d, teff;
  logic                   wr_coef, rd_coef, is_last;

  assign teff = (taps_q == '0 || taps_q > pDATA_WIDTH'(pTAP_MAX)) ? IW'(pTAP_MAX) : IW'(taps_q);
  assign prod = pDATA_WIDTH'($signed(bus.tap_Do) * $signed(bus.data_Do));
  assign wr_coef = (bus.awaddr >= COEF_LO) && (bus.awaddr < COEF_HI);
  assign rd_coef = (bus.araddr >= COEF_LO) && (bus.araddr < COEF_HI);
  assign is_last = (nout_q + pDATA_WIDTH'(1)) == len_q;

  assign bus.awready   = (ax_q == X_WR);
  assign bus.wready    = (ax_q == X_WR);
  assign bus.arready   = (ax_q == X_RA);
  assign bus.rvalid    = (ax_q == X_RD);
  assign bus.rdata     = rdata_q;
  assign bus.ss_tready = (st_q == S_WAIT);
  assign bus.sm_tvalid = (st_q == S_OUT);
  assign bus.sm_tdata  = (st_q == S_OUT) ? acc_q : '0;
  assign bus.sm_tlast  = (st_q == S_OUT) && is_last;
  assign bus.tap_EN    = 1'b1;
  assign bus.data_EN   = 1'b1;

  always_comb begin
    st_d = st_q;  ax_d = ax_q;
    ap_start_d = ap_start_q;  ap_done_d = ap_done_q;  ap_idle_d = ap_idle_q;
    err_d = err_q;  last_rd_d = last_rd_q;  mac_v_d = 1'b0;
    len_d = len_q;  taps_d = taps_q;  acc_d = acc_q;  nout_d = nout_q;
    rdata_d = rdata_q;  wptr_d = wptr_q;  k_d = k_q;  hidx_d = hidx_q;
    bus.tap_WE = '0;  bus.tap_Di = '0;  bus.tap_A = '0;
    bus.data_WE = '0; bus.data_Di = '0; bus.data_A = '0;

    // Coefficient BRAM is shared: AXI side only touches it while idle, engine only in MAC.
    case (ax_q)
      X_IDLE: begin
        if (bus.awvalid && bus.wvalid && (!bus.arvalid || last_rd_q)) ax_d = X_WR;
        else if (bus.arvalid) ax_d = X_RA;
      end
      X_WR: begin
        ax_d = X_IDLE;
        last_rd_d = 1'b0;
        if (ap_idle_q) begin
          if (bus.awaddr == A_CTRL) begin
            if (bus.wdata[0]) begin
              ap_start_d = 1'b1; ap_idle_d = 1'b0; ap_done_d = 1'b0; err_d = 1'b0;
            end
          end else if (bus.awaddr == A_LEN) begin
            len_d = bus.wdata;
          end else if (bus.awaddr == A_TAPS) begin
            taps_d = bus.wdata;
          end else if (wr_coef) begin
            bus.tap_WE = '1;
            bus.tap_Di = bus.wdata;
            bus.tap_A  = {bus.awaddr[pADDR_WIDTH-1:2] - IW'(8), 2'b00};
          end
        end
      end
      X_RA: begin
        ax_d = X_RD;
        last_rd_d = 1'b1;
        rdata_d = '0;
        if (bus.araddr == A_CTRL) begin
          rdata_d[3:0] = {err_q, ap_idle_q, ap_done_q, ap_start_q};
          ap_done_d = 1'b0;
        end else if (bus.araddr == A_LEN) begin
          rdata_d = len_q;
        end else if (bus.araddr == A_TAPS) begin
          rdata_d = taps_q;
        end else if (rd_coef) begin
          if (ap_idle_q) begin
            bus.tap_A = {bus.araddr[pADDR_WIDTH-1:2] - IW'(8), 2'b00};
            ax_d = X_RW;
          end else begin
            rdata_d = '1;
          end
        end
      end
      X_RW: begin
        rdata_d = bus.tap_Do;
        ax_d = X_RD;
      end
      X_RD: if (bus.rready) ax_d = X_IDLE;
      default: ax_d = X_IDLE;
    endcase

    case (st_q)
      S_IDLE: if (ap_start_q) begin
        st_d = S_CLEAR;
        k_d  = '0;
      end
      S_CLEAR: begin
        bus.data_WE = '1;
        bus.data_A  = {k_q, 2'b00};
        k_d = k_q + IW'(1);
        if (k_q == LAST_IDX) begin
          wptr_d = '0;
          nout_d = '0;
          if (len_q == '0) begin
            st_d = S_IDLE; ap_done_d = 1'b1; ap_idle_d = 1'b1; ap_start_d = 1'b0;
          end else begin
            st_d = S_WAIT;
          end
        end
      end
      S_WAIT: if (bus.ss_tvalid) begin
        bus.data_WE = '1;
        bus.data_A  = {wptr_q, 2'b00};
        bus.data_Di = bus.ss_tdata;
        ap_start_d  = 1'b0;
        if (bus.ss_tlast != is_last) err_d = 1'b1;
        k_d = '0;  hidx_d = wptr_q;  acc_d = '0;
        st_d = S_MAC;
      end
      // Issue one tap/history read per cycle; products land one cycle later.
      S_MAC: begin
        if (mac_v_q) acc_d = acc_q + prod;
        if (k_q != teff) begin
          bus.tap_A  = {k_q, 2'b00};
          bus.data_A = {hidx_q, 2'b00};
          mac_v_d = 1'b1;
          k_d = k_q + IW'(1);
          hidx_d = (hidx_q == '0) ? LAST_IDX : hidx_q - IW'(1);
        end else begin
          st_d = S_OUT;
        end
      end
      S_OUT: if (bus.sm_tready) begin
        wptr_d = (wptr_q == LAST_IDX) ? '0 : wptr_q + IW'(1);
        nout_d = nout_q + pDATA_WIDTH'(1);
        if (is_last) begin
          st_d = S_IDLE; ap_done_d = 1'b1; ap_idle_d = 1'b1;
        end else begin
          st_d = S_WAIT;
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      st_q <= S_IDLE;  ax_q <= X_IDLE;
      ap_start_q <= 1'b0;  ap_done_q <= 1'b0;  ap_idle_q <= 1'b1;  err_q <= 1'b0;
      last_rd_q <= 1'b0;  mac_v_q <= 1'b0;
      len_q <= '0;  taps_q <= pDATA_WIDTH'(pTAP_MAX);  acc_q <= '0;
      nout_q <= '0;  rdata_q <= '0;
      wptr_q <= '0;  k_q <= '0;  hidx_q <= '0;
    end else begin
      st_q <= st_d;  ax_q <= ax_d;
      ap_start_q <= ap_start_d;  ap_done_q <= ap_done_d;  ap_idle_q <= ap_idle_d;  err_q <= err_d;
      last_rd_q <= last_rd_d;  mac_v_q <= mac_v_d;
      len_q <= len_d;  taps_q <= taps_d;  acc_q <= acc_d;
      nout_q <= nout_d;  rdata_q <= rdata_d;
      wptr_q <= wptr_d;  k_q <= k_d;  hidx_q <= hidx_d;
    end
  end
endmodule

// File: tb/tb_fir_stream_engine.sv
// Self-checking bench for fir_stream_engine: BRAM models, AXI-Lite/stream
// drivers and a convolution reference model over the whole job's samples.
module tb_fir_stream_engine;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int TM = 11;

  logic clk, rst_n;
  int checks = 0;
  int errors = 0;

  fir_stream_engine_if #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) bus ();

  fir_stream_engine #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .pTAP_MAX(TM)) dut (
    .axis_clk  (clk),
    .axis_rst_n(rst_n),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  logic [31:0] tap_mem  [0:1023];
  logic [31:0] data_mem [0:1023];

  always @(posedge clk) begin
    if (bus.tap_EN) begin
      for (int b = 0; b < 4; b++)
        if (bus.tap_WE[b]) tap_mem[bus.tap_A[11:2]][b*8 +: 8] <= bus.tap_Di[b*8 +: 8];
      bus.tap_Do <= tap_mem[bus.tap_A[11:2]];
    end
    if (bus.data_EN) begin
      for (int b = 0; b < 4; b++)
        if (bus.data_WE[b]) data_mem[bus.data_A[11:2]][b*8 +: 8] <= bus.data_Di[b*8 +: 8];
      bus.data_Do <= data_mem[bus.data_A[11:2]];
    end
  end

  // Reference model state
  logic [31:0] coef_m [TM];
  int unsigned taps_m;
  logic [31:0] xs [$];

  function automatic logic [31:0] ref_out(input int n);
    logic [31:0] s;
    int t;
    s = '0;
    t = (taps_m == 0 || taps_m > TM) ? TM : int'(taps_m);
    for (int k = 0; k < t; k++)
      if (n - k >= 0) s = s + 32'($signed(coef_m[k]) * $signed(xs[n-k]));
    return s;
  endfunction

  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d);
    int w;
    w = 0;
    @(negedge clk);
    bus.awaddr = a; bus.awvalid = 1'b1; bus.wdata = d; bus.wvalid = 1'b1;
    while (!(bus.awready && bus.wready) && w < 50) begin @(negedge clk); w++; end
    if (!(bus.awready && bus.wready)) begin
      checks++; errors++;
      $display("FAIL axi_write_timeout addr=%h got awready=%b want 1", a, bus.awready);
    end
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d);
    int w;
    w = 0;
    d = 'x;
    @(negedge clk);
    bus.araddr = a; bus.arvalid = 1'b1;
    while (!bus.arready && w < 50) begin @(negedge clk); w++; end
    if (!bus.arready) begin
      checks++; errors++;
      $display("FAIL axi_read_timeout addr=%h got arready=0 want 1", a);
    end
    @(posedge clk); #1;
    bus.arvalid = 1'b0; bus.rready = 1'b1;
    w = 0;
    @(negedge clk);
    while (!bus.rvalid && w < 50) begin @(negedge clk); w++; end
    if (!bus.rvalid) begin
      checks++; errors++;
      $display("FAIL axi_rvalid_timeout addr=%h got rvalid=0 want 1", a);
    end
    d = bus.rdata;
    @(posedge clk); #1;
    bus.rready = 1'b0;
  endtask

  task automatic set_coefs();
    for (int k = 0; k < TM; k++) axi_write(AW'(32'h20 + 4*k), coef_m[k]);
  endtask

  task automatic feed(input int tlast_idx);
    int n, w;
    n = xs.size();
    for (int i = 0; i < n; i++) begin
      w = 0;
      @(negedge clk);
      bus.ss_tvalid = 1'b1; bus.ss_tdata = xs[i];
      bus.ss_tlast  = (tlast_idx < 0) ? (i == n-1) : (i == tlast_idx);
      while (!bus.ss_tready && w < 300) begin @(negedge clk); w++; end
      if (!bus.ss_tready) begin
        checks++; errors++;
        $display("FAIL feed_timeout sample=%0d got ss_tready=0 want 1", i);
        bus.ss_tvalid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      bus.ss_tvalid = 1'b0; bus.ss_tlast = 1'b0;
    end
  endtask

  task automatic collect(input int stall_idx);
    int n, w;
    logic [31:0] e;
    n = xs.size();
    for (int i = 0; i < n; i++) begin
      w = 0;
      e = ref_out(i);
      @(negedge clk);
      while (!bus.sm_tvalid && w < 300) begin @(negedge clk); w++; end
      if (!bus.sm_tvalid) begin
        checks++; errors++;
        $display("FAIL collect_timeout out=%0d got sm_tvalid=0 want 1", i);
        return;
      end
      if (i == stall_idx) begin
        for (int c = 0; c < 10; c++) begin
          checks++;
          if ({bus.sm_tvalid, bus.ss_tready, bus.sm_tdata} !== {1'b1, 1'b0, e}) begin
            errors++;
            $display("FAIL stall out=%0d cyc=%0d got v=%b ssrdy=%b d=%h want v=1 ssrdy=0 d=%h",
                     i, c, bus.sm_tvalid, bus.ss_tready, bus.sm_tdata, e);
          end
          @(negedge clk);
        end
      end
      checks++;
      if (bus.sm_tdata !== e) begin
        errors++;
        $display("FAIL out_data out=%0d got %h want %h", i, bus.sm_tdata, e);
      end
      checks++;
      if (bus.sm_tlast !== (i == n-1)) begin
        errors++;
        $display("FAIL out_last out=%0d got %b want %b", i, bus.sm_tlast, (i == n-1));
      end
      bus.sm_tready = 1'b1;
      @(posedge clk); #1;
      bus.sm_tready = 1'b0;
    end
  endtask

  task automatic run_job(input int stall_idx, input int tlast_idx, input bit busy_poke);
    int n;
    logic [31:0] r;
    logic exp_err;
    n = xs.size();
    exp_err = (tlast_idx >= 0) && (tlast_idx != n-1);
    axi_write(12'h010, 32'(n));
    axi_write(12'h000, 32'h1);
    axi_read(12'h000, r);
    checks++;
    if (r !== 32'h1) begin errors++; $display("FAIL ctrl_started got %h want %h", r, 32'h1); end
    if (busy_poke) begin
      axi_write(12'h020, 32'hDEAD_BEEF);
      axi_write(12'h010, 32'd99);
      axi_write(12'h014, 32'd1);
      axi_write(12'h000, 32'h1);
      axi_read(12'h020, r);
      checks++;
      if (r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL busy_coef_read got %h want ffffffff", r); end
      axi_read(12'h010, r);
      checks++;
      if (r !== 32'(n)) begin errors++; $display("FAIL busy_len_write got %h want %h", r, 32'(n)); end
    end
    fork
      feed(tlast_idx);
      collect(stall_idx);
    join
    axi_read(12'h000, r);
    checks++;
    if (r !== {28'd0, exp_err, 3'b110}) begin
      errors++; $display("FAIL ctrl_done got %h want %h", r, {28'd0, exp_err, 3'b110});
    end
    axi_read(12'h000, r);
    checks++;
    if (r !== {28'd0, exp_err, 3'b100}) begin
      errors++; $display("FAIL ctrl_rtc got %h want %h", r, {28'd0, exp_err, 3'b100});
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    @(negedge clk);
    checks++;
    if ({bus.awready, bus.wready, bus.arready, bus.rvalid, bus.ss_tready, bus.sm_tvalid,
         bus.sm_tlast, bus.sm_tdata, bus.tap_WE, bus.data_WE, bus.tap_EN, bus.data_EN}
        !== {7'b0, 32'h0, 4'h0, 4'h0, 2'b11}) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b%b%b rv=%b ss=%b sm=%b last=%b d=%h we=%h/%h en=%b%b want zeros en=11",
               bus.awready, bus.wready, bus.arready, bus.rvalid, bus.ss_tready, bus.sm_tvalid,
               bus.sm_tlast, bus.sm_tdata, bus.tap_WE, bus.data_WE, bus.tap_EN, bus.data_EN);
    end
    rst_n = 1'b1;
    axi_read(12'h000, r);
    checks++; if (r !== 32'h4) begin errors++; $display("FAIL reset_ctrl got %h want 4", r); end
    axi_read(12'h010, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_len got %h want 0", r); end
    axi_read(12'h014, r);
    checks++; if (r !== 32'd11) begin errors++; $display("FAIL reset_taps got %h want b", r); end
  endtask

  task automatic test_regs();
    logic [31:0] r;
    axi_write(12'h014, 32'd5);
    axi_read(12'h014, r);
    checks++; if (r !== 32'd5) begin errors++; $display("FAIL taps_rw got %h want 5", r); end
    for (int k = 0; k < TM; k++) coef_m[k] = 32'(k + 1);
    set_coefs();
    for (int k = 0; k < TM; k++) begin
      axi_read(AW'(32'h20 + 4*k), r);
      checks++;
      if (r !== coef_m[k]) begin errors++; $display("FAIL coef_rw k=%0d got %h want %h", k, r, coef_m[k]); end
    end
    axi_read(12'h04C, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL unmapped_past_coef got %h want 0", r); end
    axi_read(12'h000, r);
    checks++; if (r !== 32'h4) begin errors++; $display("FAIL idle_ctrl got %h want 4", r); end
  endtask

  task automatic test_impulse();
    axi_write(12'h014, 32'd11);
    taps_m = 11;
    xs = '{32'd1, 32'd0, 32'd0, 32'd0};
    run_job(-1, -1, 1'b0);
  endtask

  task automatic test_wrap();
    axi_write(12'h014, 32'd3);
    taps_m = 3;
    for (int k = 0; k < TM; k++) coef_m[k] = (k < 3) ? 32'd1 : $urandom_range(100, 1);
    set_coefs();
    xs.delete();
    for (int i = 1; i <= 14; i++) xs.push_back(32'(i));
    run_job(-1, -1, 1'b0);
  endtask

  task automatic test_backpressure();
    xs.delete();
    for (int i = 0; i < 5; i++) xs.push_back($urandom_range(1000, 0));
    run_job(1, -1, 1'b0);
  endtask

  task automatic test_busy_write();
    logic [31:0] r;
    xs.delete();
    for (int i = 0; i < 4; i++) xs.push_back($urandom);
    run_job(-1, -1, 1'b1);
    axi_read(12'h020, r);
    checks++; if (r !== coef_m[0]) begin errors++; $display("FAIL coef_after_busy got %h want %h", r, coef_m[0]); end
    axi_read(12'h014, r);
    checks++; if (r !== 32'(taps_m)) begin errors++; $display("FAIL taps_after_busy got %h want %h", r, taps_m); end
  endtask

  task automatic test_tlast_err();
    xs.delete();
    for (int i = 0; i < 4; i++) xs.push_back($urandom_range(50, 0));
    run_job(-1, 1, 1'b0);
    xs.delete();
    for (int i = 0; i < 3; i++) xs.push_back($urandom_range(50, 0));
    run_job(-1, -1, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] r;
    int unsigned tlist [4];
    tlist = '{$urandom_range(11, 1), 0, 13, $urandom_range(11, 1)};
    for (int it = 0; it < 4; it++) begin
      taps_m = tlist[it];
      axi_write(12'h014, 32'(taps_m));
      axi_read(12'h014, r);
      checks++; if (r !== 32'(taps_m)) begin errors++; $display("FAIL rand_taps got %h want %h", r, taps_m); end
      for (int k = 0; k < TM; k++) coef_m[k] = $urandom;
      set_coefs();
      xs.delete();
      for (int i = 0; i < 14; i++) xs.push_back($urandom);
      run_job((it == 3) ? 13 : -1, -1, 1'b0);
    end
  endtask

  task automatic test_zero_length();
    logic [31:0] r;
    bit seen;
    xs.delete();
    axi_write(12'h010, 32'd0);
    axi_write(12'h000, 32'h1);
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.ss_tready || bus.sm_tvalid) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL zero_len_traffic got stream activity want none"); end
    axi_read(12'h000, r);
    checks++; if (r !== 32'h6) begin errors++; $display("FAIL zero_len_done got %h want 6", r); end
    axi_read(12'h000, r);
    checks++; if (r !== 32'h4) begin errors++; $display("FAIL zero_len_rtc got %h want 4", r); end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] r;
    axi_write(12'h010, 32'd5);
    axi_write(12'h000, 32'h1);
    repeat (20) @(negedge clk);
    checks++; if (bus.ss_tready !== 1'b1) begin errors++; $display("FAIL midrun_waiting got ss_tready=%b want 1", bus.ss_tready); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.ss_tready !== 1'b0) begin errors++; $display("FAIL midrun_abort got ss_tready=%b want 0", bus.ss_tready); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    axi_read(12'h000, r);
    checks++; if (r !== 32'h4) begin errors++; $display("FAIL midrun_ctrl got %h want 4", r); end
    axi_read(12'h010, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL midrun_len got %h want 0", r); end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clk = 1'b0; rst_n = 1'b0;
    bus.awvalid = 1'b0; bus.awaddr = '0; bus.wvalid = 1'b0; bus.wdata = '0;
    bus.arvalid = 1'b0; bus.araddr = '0; bus.rready = 1'b0;
    bus.ss_tvalid = 1'b0; bus.ss_tdata = '0; bus.ss_tlast = 1'b0; bus.sm_tready = 1'b0;
    taps_m = 11;
    repeat (3) @(negedge clk);
    test_reset();
    test_regs();
    test_impulse();
    test_wrap();
    test_backpressure();
    test_busy_write();
    test_tlast_err();
    test_random();
    test_zero_length();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
